// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared LED constants and shift-out state encoding
package led_pkg;

  // LED count and chain length shared with the pattern generator
  localparam int LED_COUNT      = 18;
  localparam int LED_CHAIN_BITS = 24;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } led_state_t;

endpackage

// File: rtl/led_shift_tick.sv
// rtl/led_shift_tick.sv - CLK_DIV phase divider with clear and one-cycle terminal tick
module led_shift_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  // Tick on the last cycle of a phase; clear holds the count at zero
  assign tick = !clear && (div_cnt == LAST);

  // Phase counter: restarts on clear or terminal count, never wraps past LAST
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (clear || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/led_shift_out.sv
// rtl/led_shift_out.sv - serializes LED frames into a latching shift-register chain (LED_SHIFT_INVERT_EN inverts the frame)
module led_shift_out
  import led_pkg::*;
#(
  parameter int N_LEDS     = LED_COUNT,
  parameter int CHAIN_BITS = LED_CHAIN_BITS,
  parameter int CLK_DIV    = 4,
  parameter int MSB_FIRST  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_LEDS-1:0] led_in,
  input  logic              update,
  output logic              sr_data,
  output logic              sr_clk,
  output logic              sr_latch,
  output logic              busy,
  output logic              done
);

  localparam int BW = $clog2(CHAIN_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_BITS - 1);

  led_state_t            state;
  logic                  pending;
  logic [BW-1:0]         bit_cnt;
  logic [CHAIN_BITS-1:0] shreg;
  logic [CHAIN_BITS-1:0] frame_word;
  logic [CHAIN_BITS-1:0] next_shreg;
  logic                  first_bit;
  logic                  next_bit;
  logic                  tick;
  logic                  tick_clear;

  // Divider idles cleared so every shifting state starts a fresh CLK_DIV phase
  assign tick_clear = (state == IDLE);

  led_shift_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(tick_clear),
    .tick (tick)
  );

  // Build the padded frame word and pick the bit order for the chain
  always_comb begin
    frame_word = '0;
    frame_word[N_LEDS-1:0] = led_in;
`ifdef LED_SHIFT_INVERT_EN
    frame_word = ~frame_word;
`endif
    if (MSB_FIRST != 0) begin
      first_bit  = frame_word[CHAIN_BITS-1];
      next_shreg = shreg << 1;
      next_bit   = next_shreg[CHAIN_BITS-1];
    end else begin
      first_bit  = frame_word[0];
      next_shreg = shreg >> 1;
      next_bit   = next_shreg[0];
    end
  end

  // Frame sequencer: capture, shift CHAIN_BITS bits, pulse latch, report done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pending  <= 1'b0;
      bit_cnt  <= '0;
      shreg    <= '0;
      sr_data  <= 1'b0;
      sr_clk   <= 1'b0;
      sr_latch <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (update || pending) begin
            shreg   <= frame_word;
            sr_data <= first_bit;
            sr_clk  <= 1'b0;
            busy    <= 1'b1;
            pending <= 1'b0;
            bit_cnt <= '0;
            state   <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (update) pending <= 1'b1;
          if (tick) begin
            sr_clk <= 1'b1;
            state  <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (update) pending <= 1'b1;
          if (tick) begin
            sr_clk <= 1'b0;
            if (bit_cnt == LAST_BIT) begin
              sr_latch <= 1'b1;
              state    <= LATCH;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              shreg   <= next_shreg;
              sr_data <= next_bit;
              state   <= SHIFT_LO;
            end
          end
        end
        LATCH: begin
          if (update) pending <= 1'b1;
          if (tick) begin
            sr_latch <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
